countdown_share_arbiter: RTL

- Shares one PastAssert-style countdown timer among NUM_REQ requesters.
- Latches one start request per requester and grants the timer round-robin.
- Issues the timer's startSignal method, then tracks the run to completion and returns a per-requester done pulse.
- Includes a watchdog that aborts a run that never completes; sits between client logic and the single shared timer instance.

---
 rtl/countdown_share_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/countdown_share_arbiter.sv
// Shares one countdown timer among NUM_REQ requesters.
// Each requester latches one start request; requests are granted round-robin,
// the timer's startSignal is issued for the owner, the run is tracked until the
// timer goes idle (or a watchdog expires), and a one-cycle done pulse is
// returned to the owner.
//
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   req__ENA/RDY     per-requester start request handshake
//   done, err        one-hot pulses: run finished / run aborted by watchdog
//   owner            index of current timer owner, ownerValid while ISSUE/RUN
//   timerStart__ENA  drives the shared timer's startSignal enable
//   timerStart__RDY  timer idle and ready to start
//   timerBusy        timer counter non-zero
//   errSticky        set on any watchdog abort, cleared only by reset
module countdown_share_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned OWNER_W = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 7
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [NUM_REQ-1:0] req__ENA,
    output logic [NUM_REQ-1:0] req__RDY,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic [OWNER_W-1:0] owner,
    output logic               ownerValid,
    output logic               timerStart__ENA,
    input  logic               timerStart__RDY,
    input  logic               timerBusy,
    output logic               errSticky
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] pending;
    logic [OWNER_W-1:0] last_grant;
    logic [TO_W-1:0]    wd;

    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] clr;
    logic               win_found;
    logic [OWNER_W-1:0] win_idx;
    int unsigned        scan;

    // A requester is ready exactly when it has nothing outstanding
    assign req__RDY = ~pending;
    assign accept   = req__ENA & ~pending;

    // One-hot owner and the pending bit retired on leaving DONE
    always_comb begin
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        clr             = (state == ST_DONE) ? owner_oh : '0;
    end

    // Round-robin pick: first pending bit after last_grant, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = 0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            scan = 32'(last_grant) + 32'(k);
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!win_found && pending[OWNER_W'(scan)]) begin
                win_found = 1'b1;
                win_idx   = OWNER_W'(scan);
            end
        end
    end

    // Arbiter FSM with registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= ST_IDLE;
            pending         <= '0;
            last_grant      <= OWNER_W'(NUM_REQ - 1);
            owner           <= '0;
            wd              <= '0;
            errSticky       <= 1'b0;
            done            <= '0;
            err             <= '0;
            timerStart__ENA <= 1'b0;
            ownerValid      <= 1'b0;
        end else begin
            pending <= (pending | accept) & ~clr;
            done    <= '0;
            err     <= '0;
            case (state)
                ST_IDLE: begin
                    // Only bits latched before this cycle take part
                    if (win_found) begin
                        owner           <= win_idx;
                        last_grant      <= win_idx;
                        timerStart__ENA <= 1'b1;
                        ownerValid      <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Start fires on the first cycle the timer is ready
                    if (timerStart__RDY) begin
                        timerStart__ENA <= 1'b0;
                        wd              <= '0;
                        state           <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // wd==0 is the timer's load cycle; busy is not valid yet
                    if (wd != '0 && !timerBusy) begin
                        done       <= owner_oh;
                        ownerValid <= 1'b0;
                        state      <= ST_DONE;
                    end else if (wd == TO_W'(TIMEOUT - 1)) begin
                        done       <= owner_oh;
                        err        <= owner_oh;
                        errSticky  <= 1'b1;
                        ownerValid <= 1'b0;
                        state      <= ST_DONE;
                    end else begin
                        wd <= wd + TO_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
